program_loader: RTL and testbench

Parametrised boot/program loader that streams instruction words into the processor's instruction memory over a valid/ready handshake. It holds the processor core in reset while loading, then releases it and raises `start` to the control unit. It also reports the word count and a running checksum. It sits between the external program source and the IM write port, and it drives the core's reset and start controls.

---
 rtl/program_loader_if.sv | 25 ++
 rtl/program_loader.sv | 117 +++++++++++
 tb/tb_program_loader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Source-stream and instruction-memory write bundle for the program loader.
// Slave modport is the loader's view; master modport is the source/IM side.
// Handshake is valid/ready; the IM write strobe is combinational from it.
interface program_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              im_en_write;
    logic [ADDR_W-1:0] im_address;
    logic [DATA_W-1:0] im_data;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, im_en_write, im_address, im_data
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, im_en_write, im_address, im_data
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: streams words into IM, holds the core in reset, then releases it and starts it.
// Latency: word accepted on edge M is in IM from M+1; core leaves reset 1 cycle after the last word, start 1 cycle later.
// Backpressure: in_ready is high for the whole LOAD state and low elsewhere; one word per cycle accepted.
module program_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    program_loader_if.slave   bus,
    output logic              cpu_reset,
    output logic              start,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] csum_q, csum_d;

    logic in_ready;
    logic hs;

    assign in_ready = (state_q == S_LOAD);
    assign hs       = bus.in_valid & in_ready;

    // Next-state and counter update; every load entry clears pointer, count and checksum.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        csum_d  = csum_q;
        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                    csum_d  = '0;
                end
            end
            S_LOAD: begin
                // load_req is deliberately not looked at here: a running load is never restarted.
                if (hs) begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    count_d = count_q + (ADDR_W + 1)'(1);
                    csum_d  = csum_q + bus.in_data;
                    if (bus.in_last) begin
                        state_d = S_RELEASE;
                    end else if (ptr_q == LAST_ADDR) begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_RELEASE: begin
                state_d = S_RUN;
            end
            S_RUN, S_ERROR: begin
                if (load_req) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                    csum_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any load straight back to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            csum_q  <= csum_d;
        end
    end

    // Control outputs decode directly from the state so they follow an async reset immediately.
    always_comb begin
        cpu_reset = !((state_q == S_RELEASE) || (state_q == S_RUN));
        start     = (state_q == S_RUN);
        done      = (state_q == S_RUN);
        error     = (state_q == S_ERROR);
    end

    assign bus.in_ready    = in_ready;
    assign bus.im_en_write = hs;
    assign bus.im_address  = ptr_q;
    assign bus.im_data     = bus.in_data;
    assign word_count      = count_q;
    assign checksum        = csum_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic clk;
    logic rst_n;
    logic la, lb;
    logic        s_valid, s_last;
    logic [15:0] s_data;

    int n_checks = 0;
    int n_errors = 0;

    program_loader_if #(.DATA_W(16), .ADDR_W(10)) a_if ();
    program_loader_if #(.DATA_W(16), .ADDR_W(10)) b_if ();

    assign a_if.in_valid = s_valid;
    assign a_if.in_data  = s_data;
    assign a_if.in_last  = s_last;
    assign b_if.in_valid = s_valid;
    assign b_if.in_data  = s_data;
    assign b_if.in_last  = s_last;

    logic        a_cpu_reset, a_start, a_done, a_error;
    logic [10:0] a_wc;
    logic [15:0] a_cs;
    logic        b_cpu_reset, b_start, b_done, b_error;
    logic [10:0] b_wc;
    logic [15:0] b_cs;

    program_loader #(.DATA_W(16), .ADDR_W(10)) dut_a (
        .clk(clk), .reset(rst_n), .load_req(la), .bus(a_if.slave),
        .cpu_reset(a_cpu_reset), .start(a_start), .done(a_done), .error(a_error),
        .word_count(a_wc), .checksum(a_cs)
    );

    program_loader #(.DATA_W(16), .ADDR_W(10), .DEPTH(4)) dut_b (
        .clk(clk), .reset(rst_n), .load_req(lb), .bus(b_if.slave),
        .cpu_reset(b_cpu_reset), .start(b_start), .done(b_done), .error(b_error),
        .word_count(b_wc), .checksum(b_cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model and write logs, fed only by the IM write port.
    logic [15:0] mem_a [1024];
    logic [9:0]  a_addr[$];
    logic [15:0] a_dat[$];
    logic [9:0]  b_addr[$];
    logic [15:0] b_dat[$];

    always @(posedge clk) begin
        if (a_if.im_en_write) begin
            mem_a[a_if.im_address] = a_if.im_data;
            a_addr.push_back(a_if.im_address);
            a_dat.push_back(a_if.im_data);
        end
        if (b_if.im_en_write) begin
            b_addr.push_back(b_if.im_address);
            b_dat.push_back(b_if.im_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic l);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        #1;
    endtask

    logic        bp_v [6];
    logic [15:0] bp_d [6];
    logic        bp_l [6];

    initial begin
        rst_n = 1'b0; la = 1'b0; lb = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        bp_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bp_d = '{16'h1111, 16'hDEAD, 16'hBEEF, 16'h2222, 16'h3333, 16'h4444};
        bp_l = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        #12;
        check("rst_cpu_reset", a_cpu_reset, 1);
        check("rst_start", a_start, 0);
        check("rst_done", a_done, 0);
        check("rst_error", a_error, 0);
        check("rst_in_ready", a_if.in_ready, 0);
        check("rst_wc", a_wc, 0);
        check("rst_cs", a_cs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic load
        la = 1'b1;
        step();
        la = 1'b0;
        check("basic_in_ready", a_if.in_ready, 1);
        check("basic_cpu_reset_load", a_cpu_reset, 1);
        a_addr.delete(); a_dat.delete();
        drive(1, 16'h4004, 0);
        check("basic_we0", a_if.im_en_write, 1);
        check("basic_addr0", a_if.im_address, 0);
        step();
        drive(1, 16'h7000, 0);
        step();
        drive(1, 16'h4002, 1);
        check("basic_addr2", a_if.im_address, 2);
        step();
        drive(0, 16'h0000, 0);
        check("basic_rel_cpu_reset", a_cpu_reset, 0);
        check("basic_rel_start", a_start, 0);
        check("basic_rel_done", a_done, 0);
        check("basic_rel_in_ready", a_if.in_ready, 0);
        check("basic_wc", a_wc, 3);
        check("basic_cs", a_cs, 16'hF006);
        step();
        check("basic_run_start", a_start, 1);
        check("basic_run_done", a_done, 1);
        check("basic_run_cpu_reset", a_cpu_reset, 0);
        check("basic_nwrites", a_addr.size(), 3);
        check("basic_im0", mem_a[0], 16'h4004);
        check("basic_im1", mem_a[1], 16'h7000);
        check("basic_im2", mem_a[2], 16'h4002);

        // Reload from RUN
        la = 1'b1;
        step();
        la = 1'b0;
        check("reload_cpu_reset", a_cpu_reset, 1);
        check("reload_start", a_start, 0);
        check("reload_done", a_done, 0);
        check("reload_wc", a_wc, 0);
        check("reload_cs", a_cs, 0);
        a_addr.delete(); a_dat.delete();
        drive(1, 16'h0001, 0);
        step();
        drive(1, 16'h0002, 1);
        step();
        drive(0, 16'h0000, 0);
        check("reload_nwrites", a_addr.size(), 2);
        if (a_addr.size() == 2) begin
            check("reload_addr0", a_addr[0], 0);
            check("reload_addr1", a_addr[1], 1);
        end
        check("reload_wc2", a_wc, 2);
        check("reload_cs2", a_cs, 16'h0003);
        step();

        // Source backpressure, with stray in_last on idle cycles
        la = 1'b1;
        step();
        la = 1'b0;
        a_addr.delete(); a_dat.delete();
        for (int i = 0; i < 6; i++) begin
            drive(bp_v[i], bp_d[i], bp_l[i]);
            check($sformatf("bp_we%0d", i), a_if.im_en_write, bp_v[i]);
            step();
        end
        drive(0, 16'h0000, 0);
        check("bp_wc", a_wc, 4);
        check("bp_cs", a_cs, 16'hAAAA);
        check("bp_cpu_reset", a_cpu_reset, 0);
        check("bp_nwrites", a_addr.size(), 4);
        if (a_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("bp_addr%0d", i), a_addr[i], i);
                check($sformatf("bp_dat%0d", i), a_dat[i], 16'h1111 * (i + 1));
            end
        end
        step();

        // Overflow on the DEPTH=4 loader
        lb = 1'b1;
        step();
        lb = 1'b0;
        b_addr.delete(); b_dat.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'(i + 1), 0);
            step();
        end
        drive(1, 16'h0005, 0);
        check("ovf_error", b_error, 1);
        check("ovf_cpu_reset", b_cpu_reset, 1);
        check("ovf_start", b_start, 0);
        check("ovf_done", b_done, 0);
        check("ovf_wc", b_wc, 4);
        check("ovf_cs", b_cs, 16'h000A);
        check("ovf_in_ready", b_if.in_ready, 0);
        check("ovf_we5", b_if.im_en_write, 0);
        step();
        drive(0, 16'h0000, 0);
        check("ovf_nwrites", b_addr.size(), 4);
        if (b_addr.size() == 4) begin
            check("ovf_addr3", b_addr[3], 3);
            check("ovf_dat3", b_dat[3], 16'h0004);
        end

        // Exact fill on the DEPTH=4 loader, starting from ERROR
        lb = 1'b1;
        step();
        lb = 1'b0;
        check("fill_error_clr", b_error, 0);
        check("fill_in_ready", b_if.in_ready, 1);
        b_addr.delete(); b_dat.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'h0100 + 16'(i), (i == 3) ? 1'b1 : 1'b0);
            step();
        end
        drive(0, 16'h0000, 0);
        check("fill_rel_cpu_reset", b_cpu_reset, 0);
        check("fill_rel_start", b_start, 0);
        check("fill_rel_error", b_error, 0);
        step();
        check("fill_run_start", b_start, 1);
        check("fill_run_done", b_done, 1);
        check("fill_run_error", b_error, 0);
        check("fill_wc", b_wc, 4);
        check("fill_nwrites", b_addr.size(), 4);
        if (b_addr.size() == 4) begin
            check("fill_addr3", b_addr[3], 3);
        end

        // Asynchronous reset in the middle of a load
        la = 1'b1;
        step();
        la = 1'b0;
        drive(1, 16'h0A0A, 0);
        step();
        drive(1, 16'h0B0B, 0);
        step();
        a_addr.delete(); a_dat.delete();
        drive(1, 16'h0C0C, 0);
        check("arst_pre_we", a_if.im_en_write, 1);
        rst_n = 1'b0;
        #1;
        check("arst_cpu_reset", a_cpu_reset, 1);
        check("arst_start", a_start, 0);
        check("arst_done", a_done, 0);
        check("arst_in_ready", a_if.in_ready, 0);
        check("arst_we", a_if.im_en_write, 0);
        check("arst_wc", a_wc, 0);
        check("arst_cs", a_cs, 0);
        check("arst_b_start", b_start, 0);
        step();
        check("arst_we_held", a_if.im_en_write, 0);
        check("arst_nwrites", a_addr.size(), 0);
        check("arst_im0", mem_a[0], 16'h0A0A);
        check("arst_im1", mem_a[1], 16'h0B0B);
        drive(0, 16'h0000, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
